// File: rtl/ysyx_22050019_icache.sv
// Direct-mapped, read-only instruction cache with 128-bit lines.
// Line requests are accepted on a simple AR/R handshake, and a full 128-bit line is returned.
// Misses are refilled from memory with a 2-beat, 64-bit AXI INCR burst.
//
// Ports:
//   clk, rst_n              clock; synchronous active-high reset (despite the name)
//   ar_valid_i/ar_ready_o   line request handshake; ar_addr_i[3:0] are ignored
//   r_valid_o/r_ready_i     line response handshake; r_data_o byte 0 in [7:0], r_resp_o code
//   fence_i_i               one-cycle pulse; invalidates every line on the next idle cycle
//   mem_ar_*                memory read address channel (len 1, size 8 bytes, INCR)
//   mem_r_*                 memory read data channel
module ysyx_22050019_icache #(
    parameter int unsigned LINES     = 64,
    parameter logic [1:0]  RESP_OKAY = 2'b00
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ar_valid_i,
    output logic         ar_ready_o,
    input  logic [31:0]  ar_addr_i,
    output logic         r_valid_o,
    output logic [127:0] r_data_o,
    output logic [1:0]   r_resp_o,
    input  logic         r_ready_i,
    input  logic         fence_i_i,
    output logic         mem_ar_valid_o,
    input  logic         mem_ar_ready_i,
    output logic [31:0]  mem_ar_addr_o,
    output logic [7:0]   mem_ar_len_o,
    output logic [2:0]   mem_ar_size_o,
    output logic [1:0]   mem_ar_burst_o,
    input  logic         mem_r_valid_i,
    output logic         mem_r_ready_o,
    input  logic [63:0]  mem_r_data_i,
    input  logic [1:0]   mem_r_resp_i,
    input  logic         mem_r_last_i
);

    localparam int unsigned IDX_W = $clog2(LINES);
    localparam int unsigned TAG_W = 28 - IDX_W;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {StIdle, StLookup, StMissAr, StMissR, StResp} state_e;

    state_e             state_q, state_d;
    logic               fence_pend_q, fence_pend_d;
    logic [27:0]        addr_q, addr_d;     // line address {tag, index}
    logic               beat_q, beat_d;
    logic [1:0]         resp_acc_q, resp_acc_d;
    logic [127:0]       line_q, line_d;     // response register
    logic [1:0]         resp_q, resp_d;
    logic [LINES-1:0]   valid_q;
    logic [TAG_W-1:0]   tag_q  [LINES];
    logic [127:0]       data_q [LINES];

    logic [IDX_W-1:0]   idx;
    logic [TAG_W-1:0]   tag;
    logic               hit;
    logic               inv_all, alloc;
    logic [1:0]         resp_new;
    logic               ar_ready, r_valid, mem_ar_valid, mem_r_ready;
    logic               unused_addr_bits;

    assign unused_addr_bits = ^ar_addr_i[3:0];

    assign idx = addr_q[IDX_W-1:0];
    assign tag = addr_q[27:IDX_W];
    assign hit = valid_q[idx] && (tag_q[idx] == tag);

    always_comb begin
        state_d      = state_q;
        fence_pend_d = fence_pend_q | fence_i_i;
        addr_d       = addr_q;
        beat_d       = beat_q;
        resp_acc_d   = resp_acc_q;
        line_d       = line_q;
        resp_d       = resp_q;
        resp_new     = resp_acc_q;
        inv_all      = 1'b0;
        alloc        = 1'b0;
        ar_ready     = 1'b0;
        r_valid      = 1'b0;
        mem_ar_valid = 1'b0;
        mem_r_ready  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (fence_pend_q) begin
                    // Fence has priority; a request arriving now waits a cycle.
                    inv_all      = 1'b1;
                    fence_pend_d = fence_i_i;
                end else begin
                    ar_ready = 1'b1;
                    if (ar_valid_i) begin
                        addr_d  = ar_addr_i[31:4];
                        state_d = StLookup;
                    end
                end
            end
            StLookup: begin
                if (hit) begin
                    line_d  = data_q[idx];
                    resp_d  = RESP_OKAY;
                    state_d = StResp;
                end else begin
                    state_d = StMissAr;
                end
            end
            StMissAr: begin
                mem_ar_valid = 1'b1;
                if (mem_ar_ready_i) begin
                    beat_d     = 1'b0;
                    resp_acc_d = RESP_OKAY;
                    state_d    = StMissR;
                end
            end
            StMissR: begin
                mem_r_ready = 1'b1;
                if (mem_r_valid_i) begin
                    // Keep the first error seen in the burst.
                    resp_new   = (resp_acc_q != RESP_OKAY) ? resp_acc_q : mem_r_resp_i;
                    resp_acc_d = resp_new;
                    beat_d     = ~beat_q;
                    if (!beat_q) begin
                        line_d[63:0] = mem_r_data_i;
                    end else begin
                        line_d[127:64] = mem_r_data_i;
                    end
                    if (mem_r_last_i) begin
                        state_d = StResp;
                        if (!beat_q) begin
                            // Burst ended after one beat: truncated line, never cached.
                            line_d[127:64] = 64'd0;
                            resp_d         = RESP_SLVERR;
                        end else begin
                            resp_d = resp_new;
                            alloc  = (resp_new == RESP_OKAY);
                        end
                    end
                end
            end
            StResp: begin
                r_valid = 1'b1;
                if (r_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Handshake outputs are forced low while reset is asserted.
    assign ar_ready_o     = ar_ready & ~rst_n;
    assign r_valid_o      = r_valid & ~rst_n;
    assign mem_ar_valid_o = mem_ar_valid & ~rst_n;
    assign mem_r_ready_o  = mem_r_ready & ~rst_n;
    assign mem_ar_addr_o  = {addr_q, 4'h0};
    assign mem_ar_len_o   = 8'd1;
    assign mem_ar_size_o  = 3'b011;
    assign mem_ar_burst_o = 2'b01;
    assign r_data_o       = line_q;
    assign r_resp_o       = resp_q;

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q      <= StIdle;
            fence_pend_q <= 1'b0;
            addr_q       <= '0;
            beat_q       <= 1'b0;
            resp_acc_q   <= RESP_OKAY;
            line_q       <= '0;
            resp_q       <= 2'b00;
            valid_q      <= '0;
        end else begin
            state_q      <= state_d;
            fence_pend_q <= fence_pend_d;
            addr_q       <= addr_d;
            beat_q       <= beat_d;
            resp_acc_q   <= resp_acc_d;
            line_q       <= line_d;
            resp_q       <= resp_d;
            if (inv_all) begin
                valid_q <= '0;
            end else if (alloc) begin
                valid_q[idx] <= 1'b1;
            end
        end
    end

    // Tag/data arrays need no reset; the valid bits guard them.
    always_ff @(posedge clk) begin
        if (alloc && !rst_n) begin
            tag_q[idx]  <= tag;
            data_q[idx] <= {mem_r_data_i, line_q[63:0]};
        end
    end

endmodule

// File: tb/tb_ysyx_22050019_icache.sv
module tb_ysyx_22050019_icache;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         ar_valid = 1'b0;
    logic         ar_ready;
    logic [31:0]  ar_addr = '0;
    logic         r_valid;
    logic [127:0] r_data;
    logic [1:0]   r_resp;
    logic         r_ready = 1'b0;
    logic         fence = 1'b0;
    logic         mem_ar_valid;
    logic         mem_ar_ready = 1'b0;
    logic [31:0]  mem_ar_addr;
    logic [7:0]   mem_ar_len;
    logic [2:0]   mem_ar_size;
    logic [1:0]   mem_ar_burst;
    logic         mem_r_valid = 1'b0;
    logic         mem_r_ready;
    logic [63:0]  mem_r_data = '0;
    logic [1:0]   mem_r_resp = '0;
    logic         mem_r_last = 1'b0;

    ysyx_22050019_icache #(.LINES(64), .RESP_OKAY(2'b00)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ar_valid_i     (ar_valid),
        .ar_ready_o     (ar_ready),
        .ar_addr_i      (ar_addr),
        .r_valid_o      (r_valid),
        .r_data_o       (r_data),
        .r_resp_o       (r_resp),
        .r_ready_i      (r_ready),
        .fence_i_i      (fence),
        .mem_ar_valid_o (mem_ar_valid),
        .mem_ar_ready_i (mem_ar_ready),
        .mem_ar_addr_o  (mem_ar_addr),
        .mem_ar_len_o   (mem_ar_len),
        .mem_ar_size_o  (mem_ar_size),
        .mem_ar_burst_o (mem_ar_burst),
        .mem_r_valid_i  (mem_r_valid),
        .mem_r_ready_o  (mem_r_ready),
        .mem_r_data_i   (mem_r_data),
        .mem_r_resp_i   (mem_r_resp),
        .mem_r_last_i   (mem_r_last)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] data;
        logic [1:0]   resp;
        bit           chk_data;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad = 0;

    // Memory-model configuration, written by the main sequence.
    int          stall_cfg = 0;
    bit          err_en = 1'b0;
    logic [31:0] err_addr = '0;
    bit          short_en = 1'b0;
    logic [31:0] short_addr = '0;
    logic [31:0] exp_ar_addr = '0;
    int          ar_count = 0;

    // Memory-model state.
    int          stall_left = 0;
    int          bidx = 0;
    bit          act = 1'b0;
    logic [31:0] cur = '0;

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] mem_beat(input logic [31:0] line, input int beat);
        if (line == 32'h8000_0000) begin
            return (beat == 1) ? 64'h5555_6666_7777_8888 : 64'h1111_2222_3333_4444;
        end
        return {~line, line + 32'(beat)};
    endfunction

    // Memory responder: inputs change on the falling edge, DUT samples on the rising edge.
    always @(negedge clk) begin
        if (rst_n) begin
            mem_ar_ready = 1'b0;
            mem_r_valid  = 1'b0;
            mem_r_last   = 1'b0;
            mem_r_resp   = 2'b00;
            mem_r_data   = '0;
            act          = 1'b0;
            stall_left   = stall_cfg;
        end else begin
            if (mem_ar_valid) begin
                check_val("mem_ar_addr", 128'(mem_ar_addr), 128'(exp_ar_addr));
                if (stall_left > 0) begin
                    mem_ar_ready = 1'b0;
                    stall_left--;
                end else begin
                    mem_ar_ready = 1'b1;
                    check_val("mem_ar_len", 128'(mem_ar_len), 128'(8'd1));
                    check_val("mem_ar_size", 128'(mem_ar_size), 128'(3'b011));
                    check_val("mem_ar_burst", 128'(mem_ar_burst), 128'(2'b01));
                    cur  = mem_ar_addr;
                    act  = 1'b1;
                    bidx = 0;
                    ar_count++;
                end
            end else begin
                mem_ar_ready = 1'b0;
                stall_left   = stall_cfg;
            end
            if (mem_r_ready && act) begin
                mem_r_valid = 1'b1;
                mem_r_data  = mem_beat(cur, bidx);
                mem_r_resp  = (bidx == 0 && err_en && cur == err_addr) ? 2'b10 : 2'b00;
                mem_r_last  = (bidx == 1) || (short_en && cur == short_addr);
                if (mem_r_last) act = 1'b0;
                bidx++;
            end else begin
                mem_r_valid = 1'b0;
                mem_r_last  = 1'b0;
            end
        end
    end

    task automatic do_req(input logic [31:0] addr, input bit exp_miss, input int hold,
                          input bit fence_pulse);
        logic [31:0] line;
        exp_t        e;
        int          w;
        int          lat;
        int          ar0;
        line        = {addr[31:4], 4'h0};
        exp_ar_addr = line;
        e.data      = {mem_beat(line, 1), mem_beat(line, 0)};
        e.resp      = 2'b00;
        e.chk_data  = 1'b1;
        if (err_en && line == err_addr) begin
            e.resp     = 2'b10;
            e.chk_data = 1'b0;
        end
        if (short_en && line == short_addr) begin
            e.data = {64'd0, mem_beat(line, 0)};
            e.resp = 2'b10;
        end
        w = 0;
        while (!ar_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        check_val("ar_ready_wait", 128'(ar_ready), 128'(1'b1));
        ar0      = ar_count;
        ar_valid = 1'b1;
        ar_addr  = addr;
        sb.push_back(e);
        @(negedge clk);
        ar_valid = 1'b0;
        lat = 1;
        while (!r_valid && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        if (!r_valid) begin
            check_val("r_valid_timeout", 128'(r_valid), 128'(1'b1));
            sb.delete();
            return;
        end
        if (!exp_miss) check_val("hit_latency", 128'(lat), 128'(2));
        check_val("mem_ar_count", 128'(ar_count - ar0), 128'(exp_miss));
        for (int h = 0; h < hold; h++) begin
            check_val("hold_valid", 128'(r_valid), 128'(1'b1));
            if (sb[0].chk_data) check_val("hold_data", r_data, sb[0].data);
            @(negedge clk);
        end
        r_ready = 1'b1;
        fence   = fence_pulse;
        if (sb.size() == 0) begin
            check_val("sb_empty", 128'(0), 128'(1));
        end else begin
            e = sb.pop_front();
            if (e.chk_data) check_val("r_data", r_data, e.data);
            check_val("r_resp", 128'(r_resp), 128'(e.resp));
        end
        @(negedge clk);
        r_ready = 1'b0;
        fence   = 1'b0;
    endtask

    initial begin
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_val("rst_ar_ready", 128'(ar_ready), 128'(1'b0));
        check_val("rst_r_valid", 128'(r_valid), 128'(1'b0));
        check_val("rst_mem_ar_valid", 128'(mem_ar_valid), 128'(1'b0));
        check_val("rst_mem_r_ready", 128'(mem_r_ready), 128'(1'b0));
        check_val("rst_r_data", r_data, 128'd0);
        check_val("rst_r_resp", 128'(r_resp), 128'(2'b00));
        rst_n = 1'b0;
        @(negedge clk);
        check_val("ar_ready_after_rst", 128'(ar_ready), 128'(1'b1));

        // Cold miss, then hit on the same line.
        do_req(32'h8000_0008, 1'b1, 0, 1'b0);
        do_req(32'h8000_000C, 1'b0, 0, 1'b0);

        // Conflict eviction: same index, different tag.
        do_req(32'h8000_0400, 1'b1, 0, 1'b0);
        do_req(32'h8000_0000, 1'b1, 0, 1'b0);
        do_req(32'h8000_0004, 1'b0, 0, 1'b0);

        // Fence during the response of another request.
        do_req(32'h8000_0010, 1'b1, 0, 1'b0);
        do_req(32'h8000_0010, 1'b0, 0, 1'b0);
        do_req(32'h8000_0020, 1'b1, 0, 1'b1);
        check_val("fence_block", 128'(ar_ready), 128'(1'b0));
        @(negedge clk);
        check_val("fence_release", 128'(ar_ready), 128'(1'b1));
        do_req(32'h8000_0010, 1'b1, 0, 1'b0);
        do_req(32'h8000_0020, 1'b1, 0, 1'b0);

        // Error on beat 0: error reported, line not allocated.
        err_en   = 1'b1;
        err_addr = 32'h8000_0100;
        do_req(32'h8000_0100, 1'b1, 0, 1'b0);
        do_req(32'h8000_0104, 1'b1, 0, 1'b0);
        err_en = 1'b0;
        do_req(32'h8000_0108, 1'b1, 0, 1'b0);
        do_req(32'h8000_010C, 1'b0, 0, 1'b0);

        // Burst cut short after one beat.
        short_en   = 1'b1;
        short_addr = 32'h8000_0200;
        do_req(32'h8000_0200, 1'b1, 0, 1'b0);
        short_en = 1'b0;
        do_req(32'h8000_0200, 1'b1, 0, 1'b0);

        // Backpressure on both memory AR and response channels.
        stall_cfg = 3;
        @(negedge clk);
        do_req(32'h8000_0300, 1'b1, 5, 1'b0);
        stall_cfg = 0;
        do_req(32'h8000_0304, 1'b0, 5, 1'b0);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ysyx_22050019_icache.md
# ysyx_22050019_icache

Direct-mapped, read-only instruction cache with 128-bit (16-byte) lines. Sits directly upstream of the fetch buffer. It accepts line-aligned read requests on a simple AR/R handshake and returns a full 128-bit line. Misses are refilled from memory with a 2-beat, 64-bit AXI INCR burst.

## Interface
- `LINES`, 64: number of lines; power of two; `IDX_W = log2(LINES)`.
- `RESP_OKAY`, 2'b00: response code for good data; errors are passed through unchanged.
- `clk` in 1: the single clock.
- `rst_n` in 1: reset; synchronous, active-high despite the name.
- `ar_valid_i` in 1: fetch-buffer line request valid.
- `ar_ready_o` out 1: cache can accept a request.
- `ar_addr_i` in 32: request address; bits [3:0] are ignored.
- `r_valid_o` out 1: line data valid.
- `r_data_o` out 128: line data; byte 0 is in [7:0].
- `r_resp_o` out 2: response code.
- `r_ready_i` in 1: fetch buffer accepts the line.
- `fence_i_i` in 1: one-cycle pulse that invalidates all lines.
- `mem_ar_valid_o` out 1, `mem_ar_ready_i` in 1, `mem_ar_addr_o` out 32: memory read address channel.
- `mem_ar_len_o` out 8: constant 8'd1.
- `mem_ar_size_o` out 3: constant 3'b011.
- `mem_ar_burst_o` out 2: constant 2'b01.
- `mem_r_valid_i` in 1, `mem_r_ready_o` out 1, `mem_r_data_i` in 64, `mem_r_resp_i` in 2, `mem_r_last_i` in 1: memory read data channel.

## Operation
- Address split:
  - offset = `addr[3:0]`, ignored.
  - index = `addr[4+IDX_W-1:4]`.
  - tag = `addr[31:4+IDX_W]`.
- Storage per line: valid bit, tag, 128-bit data. All valid bits clear on reset.
- States: IDLE, LOOKUP, MISS_AR, MISS_R, RESP.
- IDLE:
  - `ar_ready_o` = ~fence_pend.
  - On `ar_valid_i & ar_ready_o`: latch address, go to LOOKUP.
  - If fence_pend: clear all valid bits this cycle, clear fence_pend, stay in IDLE.
- LOOKUP (one cycle):
  - Hit = valid[index] & tag match. On hit: latch line into the response register, set resp = OKAY, go to RESP.
  - On miss: go to MISS_AR.
- MISS_AR:
  - `mem_ar_valid_o`=1, `mem_ar_addr_o` = {tag, index, 4'b0}.
  - Address is held stable until `mem_ar_ready_i`, then go to MISS_R.
- MISS_R:
  - `mem_r_ready_o`=1.
  - A 1-bit beat counter steers beat 0 to [63:0] and beat 1 to [127:64].
  - Error responses are accumulated: the first non-OKAY `mem_r_resp_i` is kept.
  - On a beat with `mem_r_last_i`: if the accumulated response is OKAY, write data/tag and set valid[index]; otherwise do not allocate, leaving the line's prior contents and valid bit untouched. Then go to RESP.
  - `mem_r_last_i` on beat 0 ends the burst: upper 64 bits are 0, resp is forced to 2'b10 (SLVERR), no allocate.
- RESP:
  - `r_valid_o`=1; data/resp held stable until `r_ready_i`, then go to IDLE.
  - Refill data is returned from the response register, not by re-reading the array.
- `fence_i_i` is sampled in every state and sets fence_pend. Invalidation happens on the next IDLE cycle; an in-flight refill still completes and is then invalidated.
- Simultaneous `ar_valid_i` and pending fence in IDLE: fence wins and the request waits.

## Timing
- Reset values:
  - state = IDLE, fence_pend = 0.
  - `ar_ready_o`, `r_valid_o`, `mem_ar_valid_o`, `mem_r_ready_o` = 0 during the reset cycle.
  - `r_data_o` = 0, `r_resp_o` = 0.
- `ar_ready_o` is combinational from state/fence_pend. It is 1 the first cycle after reset deasserts.
- Hit latency: AR handshake at cycle T, LOOKUP at T+1, `r_valid_o` at T+2.
- Miss latency: `mem_ar_valid_o` at T+2; `r_valid_o` one cycle after the `mem_r_last_i` handshake.
- Hit throughput: one request per 3 cycles when `r_ready_i` is held high. Requests are not pipelined; `ar_ready_o`=0 outside IDLE.
- Reset mid-refill abandons the burst. Memory is on the same reset, so no stale beats are accepted.

## Test plan
- Cold miss:
  - Stimulus: reset, request 0x8000_0008; memory returns beats 0x1111_2222_3333_4444, then 0x5555_6666_7777_8888 (last).
  - Required: `mem_ar_addr_o`=0x8000_0000 with len=1, size=3, burst=1; `r_data_o`=0x5555…8888_1111…4444, resp 0.
- Hit after fill:
  - Stimulus: request 0x8000_000C, handshake at cycle T.
  - Required: no memory AR; `r_valid_o` at T+2 with the same 128-bit line.
- Conflict eviction (LINES=64):
  - Stimulus: fill 0x8000_0000, then request 0x8000_0400 (same index, new tag), then 0x8000_0000 again.
  - Required: a miss each time, with `mem_ar_addr_o` 0x8000_0400 then 0x8000_0000.
- Fence:
  - Stimulus: fill 0x8000_0010, pulse `fence_i_i` during RESP of another request, then re-request 0x8000_0010.
  - Required: `ar_ready_o`=0 for one IDLE cycle, then a miss.
- Error refill:
  - Stimulus: `mem_r_resp_i`=2'b10 on beat 0.
  - Required: `r_resp_o`=2'b10; the next request to the same line misses.
- Backpressure:
  - Stimulus: hold `r_ready_i`=0 for 5 cycles in RESP, and stall `mem_ar_ready_i` 3 cycles.
  - Required: `r_data_o`/`mem_ar_addr_o` stable, no duplicate memory AR.
